// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: ALUControl codes, opcodes,
// funct3/funct7 values and the sequencing FSM state type.
package alu_pkg;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SHIFT = 3'b101;
    localparam logic [2:0] ALU_COMP  = 3'b110;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWb
    } state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of an OP / OP-IMM instruction into ALUControl, the
// funct7 forwarded to the ALU, the R-type flag and the illegal flag.
module alu_decode
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [2:0] o_alu_ctrl,
    output logic [6:0] o_funct7,
    output logic       o_is_rtype,
    output logic       o_illegal
);

    logic w_is_op;
    logic w_is_opimm;
    logic w_is_shift;
    logic w_f7_ok;

    assign w_is_op    = (i_opcode == OPC_OP);
    assign w_is_opimm = (i_opcode == OPC_OPIMM);
    assign w_is_shift = (i_funct3 == F3_SLL) || (i_funct3 == F3_SR);
    assign o_is_rtype = w_is_op;

    // The alternate funct7 is only meaningful for SUB/SRA (R-type) and SRAI.
    always_comb begin
        w_f7_ok = 1'b0;
        if (i_funct7 == F7_BASE) begin
            w_f7_ok = 1'b1;
        end else if (i_funct7 == F7_ALT) begin
            if (w_is_op) begin
                w_f7_ok = (i_funct3 == F3_ADD) || (i_funct3 == F3_SR);
            end else begin
                w_f7_ok = (i_funct3 == F3_SR);
            end
        end
    end

    assign o_illegal = !(w_is_op || w_is_opimm) || ((w_is_op || w_is_shift) && !w_f7_ok);
    assign o_funct7  = (w_is_op || w_is_shift) ? i_funct7 : 7'd0;

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        unique case (i_funct3)
            F3_ADD:  o_alu_ctrl = (w_is_op && i_funct7[5]) ? ALU_SUB : ALU_ADD;
            F3_SLL:  o_alu_ctrl = ALU_SHIFT;
            F3_SLT:  o_alu_ctrl = ALU_COMP;
            F3_SLTU: o_alu_ctrl = ALU_COMP;
            F3_XOR:  o_alu_ctrl = ALU_XOR;
            F3_SR:   o_alu_ctrl = ALU_SHIFT;
            F3_OR:   o_alu_ctrl = ALU_OR;
            F3_AND:  o_alu_ctrl = ALU_AND;
            default: o_alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-phase ALU front end: accept an OP/OP-IMM instruction, read the register
// file, present stable ALU operands, then write the captured result back.
module alu_issue_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RF_AW = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_instr_valid,
    input  logic [31:0]      i_instr,
    output logic             o_instr_ready,
    output logic [RF_AW-1:0] o_rs1_addr,
    output logic [RF_AW-1:0] o_rs2_addr,
    input  logic [XLEN-1:0]  i_rs1_data,
    input  logic [XLEN-1:0]  i_rs2_data,
    output logic [XLEN-1:0]  o_alu_a,
    output logic [XLEN-1:0]  o_alu_b,
    output logic [4:0]       o_alu_shamt,
    output logic [2:0]       o_alu_funct3,
    output logic [6:0]       o_alu_funct7,
    output logic [2:0]       o_alu_ctrl,
    input  logic [XLEN-1:0]  i_alu_result,
    output logic             o_wb_valid,
    output logic [RF_AW-1:0] o_wb_rd,
    output logic [XLEN-1:0]  o_wb_data,
    output logic             o_illegal
);
    import alu_pkg::*;

    state_e           r_state;
    logic [31:0]      r_instr;
    logic [XLEN-1:0]  r_alu_a;
    logic [XLEN-1:0]  r_alu_b;
    logic [4:0]       r_alu_shamt;
    logic [2:0]       r_alu_funct3;
    logic [6:0]       r_alu_funct7;
    logic [2:0]       r_alu_ctrl;
    logic             r_wb_valid;
    logic [RF_AW-1:0] r_wb_rd;
    logic [XLEN-1:0]  r_wb_data;

    logic [2:0]       w_ctrl;
    logic [6:0]       w_funct7;
    logic             w_is_rtype;
    logic             w_illegal;
    logic [XLEN-1:0]  w_imm;
    logic [4:0]       w_rd;

    alu_decode u_decode (
        .i_opcode   (r_instr[6:0]),
        .i_funct3   (r_instr[14:12]),
        .i_funct7   (r_instr[31:25]),
        .o_alu_ctrl (w_ctrl),
        .o_funct7   (w_funct7),
        .o_is_rtype (w_is_rtype),
        .o_illegal  (w_illegal)
    );

    assign w_imm = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
    assign w_rd  = r_instr[11:7];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_instr      <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_shamt  <= '0;
            r_alu_funct3 <= '0;
            r_alu_funct7 <= '0;
            r_alu_ctrl   <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_instr_valid) begin
                        r_instr <= i_instr;
                        r_state <= StRead;
                    end
                end
                StRead: begin
                    // Rejected instructions leave the ALU inputs untouched.
                    if (w_illegal) begin
                        r_state <= StIdle;
                    end else begin
                        r_alu_a      <= i_rs1_data;
                        r_alu_b      <= w_is_rtype ? i_rs2_data : w_imm;
                        r_alu_shamt  <= w_is_rtype ? i_rs2_data[4:0] : r_instr[24:20];
                        r_alu_funct3 <= r_instr[14:12];
                        r_alu_funct7 <= w_funct7;
                        r_alu_ctrl   <= w_ctrl;
                        r_state      <= StExec;
                    end
                end
                StExec: begin
                    r_wb_data  <= i_alu_result;
                    r_wb_rd    <= RF_AW'(w_rd);
                    r_wb_valid <= (w_rd != 5'd0);
                    r_state    <= StWb;
                end
                StWb: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_instr_ready = (r_state == StIdle);
    assign o_illegal     = (r_state == StRead) && w_illegal;
    assign o_rs1_addr    = RF_AW'(r_instr[19:15]);
    assign o_rs2_addr    = RF_AW'(r_instr[24:20]);
    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_shamt   = r_alu_shamt;
    assign o_alu_funct3  = r_alu_funct3;
    assign o_alu_funct7  = r_alu_funct7;
    assign o_alu_ctrl    = r_alu_ctrl;
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_rd       = r_wb_rd;
    assign o_wb_data     = r_wb_data;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: register file and ALU models feed the DUT, while an
// instruction-level model predicts every output cycle by cycle.
module tb_alu_issue_ctrl;

    localparam int NT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_shamt;
    logic [2:0]  alu_funct3, alu_ctrl;
    logic [6:0]  alu_funct7;
    logic        wb_valid, illegal;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic [31:0] rf [32];
    logic        rst_s = 1'b1;
    int          n_cmp = 0;
    int          n_fail = 0;

    // Hand-computed expectations per transaction, in issue order.
    logic [31:0] lit_res  [NT] = '{32'd8, 32'd6, 32'h10, 32'd4, 32'd6, 32'd0, 32'hF800_0000,
                                   32'd1, 32'd0, 32'hFFFF_FF00, 32'hFF, 32'd0, 32'd0, 32'd8,
                                   32'd16};
    logic [2:0]  lit_ctrl [NT] = '{3'd0, 3'd1, 3'd5, 3'd0, 3'd0, 3'd0, 3'd5, 3'd6, 3'd6,
                                   3'd4, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [31:0] lit_b    [NT] = '{32'd3, 32'd4, 32'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h404,
                                   32'd1, 32'd1, 32'hFF, 32'h0F, 32'd0, 32'd0, 32'd3, 32'd9};
    bit          lit_ill  [NT] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0};

    alu_issue_ctrl #(
        .XLEN  (32),
        .RF_AW (5)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instr_valid (instr_valid),
        .i_instr       (instr),
        .o_instr_ready (instr_ready),
        .o_rs1_addr    (rs1_addr),
        .o_rs2_addr    (rs2_addr),
        .i_rs1_data    (rs1_data),
        .i_rs2_data    (rs2_data),
        .o_alu_a       (alu_a),
        .o_alu_b       (alu_b),
        .o_alu_shamt   (alu_shamt),
        .o_alu_funct3  (alu_funct3),
        .o_alu_funct7  (alu_funct7),
        .o_alu_ctrl    (alu_ctrl),
        .i_alu_result  (alu_result),
        .o_wb_valid    (wb_valid),
        .o_wb_rd       (wb_rd),
        .o_wb_data     (wb_data),
        .o_illegal     (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rst_s <= rst;

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];

    // Single-cycle ALU driven by the DUT's operand outputs.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: begin
                if (alu_funct3 == 3'b001) alu_result = alu_a << alu_shamt;
                else if (alu_funct7[5])   alu_result = $signed(alu_a) >>> alu_shamt;
                else                      alu_result = alu_a >> alu_shamt;
            end
            3'b110: begin
                if (alu_funct3 == 3'b011) alu_result = {31'b0, alu_a < alu_b};
                else                      alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            end
            default: alu_result = '0;
        endcase
    end

    function automatic logic [31:0] rd_rf(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : rf[a];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    initial begin : compare
        int          cyc, hs, m_k, n_txn;
        bit          txn, zero_hold, m_ill, busy, exp_wb, exp_ill, is_r, is_i, is_sh;
        logic [31:0] m_ins, m_a, m_b, m_res, r2, l_a, l_b;
        logic [4:0]  m_sh, l_sh;
        logic [2:0]  m_f3, m_ctrl, l_f3, l_ctrl;
        logic [6:0]  m_f7, l_f7;
        cyc = 0; hs = 0; m_k = 0; n_txn = 0;
        txn = 0; zero_hold = 1; m_ill = 0;
        m_ins = '0; m_a = '0; m_b = '0; m_res = '0; m_sh = '0; m_f3 = '0; m_f7 = '0;
        m_ctrl = '0;
        l_a = '0; l_b = '0; l_sh = '0; l_f3 = '0; l_f7 = '0; l_ctrl = '0;
        forever begin
            @(negedge clk);
            cyc++;
            busy = 0;
            if (rst_s) begin
                chk("rst_ready", 32'(instr_ready), 32'd1);
                chk("rst_wb_valid", 32'(wb_valid), 32'd0);
                chk("rst_illegal", 32'(illegal), 32'd0);
                chk("rst_alu_a", alu_a, 32'd0);
                chk("rst_alu_b", alu_b, 32'd0);
                chk("rst_ctl", {12'd0, alu_shamt, alu_funct3, alu_funct7, alu_ctrl}, 32'd0);
                chk("rst_rs_addr", {22'd0, rs1_addr, rs2_addr}, 32'd0);
                chk("rst_wb", {wb_data[26:0], wb_rd} | {27'd0, wb_data[31:27]}, 32'd0);
                txn = 0; zero_hold = 1;
                l_a = '0; l_b = '0; l_sh = '0; l_f3 = '0; l_f7 = '0; l_ctrl = '0;
            end else begin
                if (txn && cyc == hs + 1) begin
                    m_f3  = m_ins[14:12];
                    is_r  = (m_ins[6:0] == 7'b0110011);
                    is_i  = (m_ins[6:0] == 7'b0010011);
                    is_sh = (m_f3 == 3'd1) || (m_f3 == 3'd5);
                    if (is_r)
                        m_ill = !(m_ins[31:25] == 7'd0 ||
                                  (m_ins[31:25] == 7'h20 && (m_f3 == 3'd0 || m_f3 == 3'd5)));
                    else if (is_i && is_sh)
                        m_ill = !(m_ins[31:25] == 7'd0 ||
                                  (m_ins[31:25] == 7'h20 && m_f3 == 3'd5));
                    else
                        m_ill = !is_i;
                    m_a  = rd_rf(m_ins[19:15]);
                    r2   = rd_rf(m_ins[24:20]);
                    m_b  = is_r ? r2 : {{20{m_ins[31]}}, m_ins[31:20]};
                    m_sh = is_r ? r2[4:0] : m_ins[24:20];
                    m_f7 = (is_r || is_sh) ? m_ins[31:25] : 7'd0;
                    case (m_f3)
                        3'd0: begin
                            if (is_r && m_ins[30]) begin m_res = m_a - m_b; m_ctrl = 3'd1; end
                            else begin m_res = m_a + m_b; m_ctrl = 3'd0; end
                        end
                        3'd1: begin m_res = m_a << m_sh; m_ctrl = 3'd5; end
                        3'd2: begin m_res = ($signed(m_a) < $signed(m_b)) ? 32'd1 : 32'd0;
                                    m_ctrl = 3'd6; end
                        3'd3: begin m_res = (m_a < m_b) ? 32'd1 : 32'd0; m_ctrl = 3'd6; end
                        3'd4: begin m_res = m_a ^ m_b; m_ctrl = 3'd4; end
                        3'd5: begin
                            if (m_ins[30]) m_res = $signed(m_a) >>> m_sh;
                            else           m_res = m_a >> m_sh;
                            m_ctrl = 3'd5;
                        end
                        3'd6: begin m_res = m_a | m_b; m_ctrl = 3'd3; end
                        default: begin m_res = m_a & m_b; m_ctrl = 3'd2; end
                    endcase
                    if (m_k < NT) begin
                        chk("lit_illegal", 32'(m_ill), 32'(lit_ill[m_k]));
                        if (!lit_ill[m_k]) begin
                            chk("lit_result", m_res, lit_res[m_k]);
                            chk("lit_ctrl", 32'(m_ctrl), 32'(lit_ctrl[m_k]));
                            chk("lit_alu_b", m_b, lit_b[m_k]);
                        end
                    end
                    chk("rs1_addr", 32'(rs1_addr), 32'(m_ins[19:15]));
                    chk("rs2_addr", 32'(rs2_addr), 32'(m_ins[24:20]));
                end
                busy    = txn && cyc > hs && cyc <= hs + (m_ill ? 1 : 3);
                exp_ill = txn && m_ill && cyc == hs + 1;
                exp_wb  = txn && !m_ill && cyc == hs + 3 && m_ins[11:7] != 5'd0;
                chk("instr_ready", 32'(instr_ready), 32'(!busy));
                chk("illegal", 32'(illegal), 32'(exp_ill));
                chk("wb_valid", 32'(wb_valid), 32'(exp_wb));
                if (exp_wb) begin
                    chk("wb_rd", 32'(wb_rd), 32'(m_ins[11:7]));
                    chk("wb_data", wb_data, m_res);
                end
                if (txn && cyc == hs + 2) begin
                    if (!m_ill) begin
                        l_a = m_a; l_b = m_b; l_sh = m_sh; l_f3 = m_f3; l_f7 = m_f7;
                        l_ctrl = m_ctrl;
                    end
                    chk("alu_a", alu_a, l_a);
                    chk("alu_b", alu_b, l_b);
                    chk("alu_shamt", 32'(alu_shamt), 32'(l_sh));
                    chk("alu_funct3", 32'(alu_funct3), 32'(l_f3));
                    chk("alu_funct7", 32'(alu_funct7), 32'(l_f7));
                    chk("alu_ctrl", 32'(alu_ctrl), 32'(l_ctrl));
                end
                if (zero_hold) begin
                    chk("idle_alu_ab", alu_a | alu_b, 32'd0);
                    chk("idle_wb", wb_data | 32'(wb_rd), 32'd0);
                    chk("idle_ctl", {12'd0, alu_shamt, alu_funct3, alu_funct7, alu_ctrl}, 32'd0);
                end
            end
            if (instr_valid && !busy && !rst) begin
                txn = 1; hs = cyc; m_ins = instr; m_ill = 0; zero_hold = 0;
                m_k = n_txn; n_txn++;
            end
        end
    end

    // Offer ins until accepted; optionally wait until the controller is idle again.
    task automatic issue(input logic [31:0] ins, input bit wait_done);
        int t;
        t = 0;
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            $display("FAIL handshake_timeout: instr_ready=%b, want 1", instr_ready);
            $fatal(1, "handshake never completed");
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        if (wait_done) begin
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    initial begin : driver
        for (int i = 0; i < 32; i++) rf[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rf[1] = 32'd5;          rf[2] = 32'd3;  issue(32'h0020_81B3, 1);  // add x3,x1,x2
        rf[1] = 32'hA;          rf[2] = 32'd4;  issue(32'h4020_81B3, 1);  // sub x3,x1,x2
        rf[1] = 32'd1;                          issue(32'h0040_9293, 1);  // slli x5,x1,4
        rf[1] = 32'd5;                          issue(32'hFFF0_8213, 1);  // addi x4,x1,-1
                                                issue(32'h0010_8013, 1);  // addi x0,x1,1
                                                issue(32'h0000_007F, 1);  // bad opcode
        rf[1] = 32'h8000_0000;                  issue(32'h4040_D313, 1);  // srai x6,x1,4
        rf[1] = 32'hFFFF_FFFF;  rf[2] = 32'd1;  issue(32'h0020_A3B3, 1);  // slt
                                                issue(32'h0020_B3B3, 1);  // sltu
                                                issue(32'h0FF0_C413, 1);  // xori x8,x1,0xff
        rf[1] = 32'hF0;         rf[2] = 32'h0F; issue(32'h0020_E4B3, 1);  // or x9,x1,x2
                                                issue(32'h4020_F1B3, 1);  // and, bad funct7
                                                issue(32'h4040_9293, 1);  // slli, bad funct7
        rf[1] = 32'd5;          rf[2] = 32'd3;  issue(32'h0020_81B3, 0);
        @(posedge clk);
        #1 rst = 1'b1;                          // lands in EXEC
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rf[1] = 32'd7;          rf[2] = 32'd9;  issue(32'h0020_81B3, 1);
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing controller that drives the single-cycle RISC-V ALU (operands A/B, shamt, funct3, funct7, 3-bit ALUControl) and consumes its Result.
- Accepts one 32-bit OP (R-type) or OP-IMM (I-type) instruction per transaction over a valid/ready handshake.
- Reads source registers through an external combinational register-file read port, holds the ALU inputs stable for one cycle, and writes the captured Result back through a one-cycle writeback strobe.
- Used as the multi-cycle ALU front end and as the self-checking driver in ALU regressions.

Parameters:
- XLEN, 32, data width of operands, Result and writeback.
- RF_AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr  in  32  RV32I instruction word.
- instr_ready  out  1  controller can accept; high only in IDLE.
- rs1_addr  out  RF_AW  register-file read address 1 (instr[19:15]).
- rs2_addr  out  RF_AW  register-file read address 2 (instr[24:20]).
- rs1_data  in  XLEN  combinational read data 1.
- rs2_data  in  XLEN  combinational read data 2.
- alu_a  out  XLEN  ALU operand A.
- alu_b  out  XLEN  ALU operand B.
- alu_shamt  out  5  shift amount.
- alu_funct3  out  3  ALU funct3.
- alu_funct7  out  7  ALU funct7.
- alu_ctrl  out  3  ALUControl code.
- alu_result  in  XLEN  ALU Result (combinational from the ALU inputs).
- wb_valid  out  1  one-cycle write strobe.
- wb_rd  out  RF_AW  destination register.
- wb_data  out  XLEN  write data.
- illegal  out  1  one-cycle pulse when an unsupported instruction is rejected.

Behaviour:
- Reset: state returns to IDLE. instr_ready=1. wb_valid=0, illegal=0. All alu_* outputs, wb_rd, wb_data and the rs*_addr outputs are 0. Asserting reset mid-transaction discards the instruction; no wb_valid or illegal is produced for it.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE -> READ: on instr_valid & instr_ready. instr is latched into an internal register; instr is ignored in every other state.
- READ: rs1_addr and rs2_addr are driven from the latched instruction. Decode runs. Operands are registered into the alu_* outputs at the end of the cycle. Next state is EXEC.
- Illegal instruction: opcode not 0110011/0010011, or an illegal funct3/funct7 combination (R-type funct7 other than 0000000, or 0100000 only with funct3 000/101; I-type shift with imm[11:5] other than 0000000/0100000, or 0100000 only with funct3 101). In READ, illegal pulses for one cycle, the FSM returns to IDLE, and the alu_* outputs keep their previous values.
- EXEC: alu_* outputs stay stable. alu_result is registered into wb_data at the end of the cycle. Next state is WB.
- WB: wb_valid=1 for exactly one cycle, with wb_rd = instr[11:7]. If rd==0, wb_valid stays 0 (the WB cycle still elapses). Next state is IDLE.
- Latency: handshake cycle = N; wb_valid is high in cycle N+3. Throughput is one instruction per 4 cycles. Back-to-back: instr_ready rises in the cycle after WB.
- ALUControl encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHIFT, 110 COMP.
- funct3 mapping: 000 -> ADD (SUB if R-type with funct7[5]=1); 111 -> AND; 110 -> OR; 100 -> XOR; 001/101 -> SHIFT; 010/011 -> COMP.
- Operand A: alu_a = rs1_data.
- Operand B: R-type alu_b = rs2_data. I-type alu_b = sign-extended instr[31:20].
- Shift amount: R-type alu_shamt = rs2_data[4:0]. I-type alu_shamt = instr[24:20].
- alu_funct3 = instr[14:12].
- alu_funct7: instr[31:25] for R-type and I-type shifts; 0 for other I-type instructions.
- ADDI never produces SUB, regardless of immediate bits.

Decomposition:
- Shared package alu_pkg holds:
  - ALUControl localparams (ALU_ADD ... ALU_COMP);
  - opcode constants OPC_OP = 7'b0110011 and OPC_OPIMM = 7'b0010011;
  - funct3 constants;
  - the FSM state encoding.
- One natural sub-module, alu_decode: combinational decode of instr into alu_ctrl, funct7 and the illegal flag. It is instantiated in READ timing.

Test Plan:
- Reset, then x1=5, x2=3, add x3,x1,x2 (0x002081B3) -> alu_a=5, alu_b=3, alu_ctrl=000; 3 cycles after handshake: wb_valid=1, wb_rd=3, wb_data=8.
- sub x3,x1,x2 (0x402081B3) with x1=0xA, x2=4 -> alu_ctrl=001, wb_data=6.
- slli x5,x1,4 (0x00409293) with x1=1 -> alu_ctrl=101, alu_shamt=4, alu_funct3=001, alu_funct7=0, wb_rd=5, wb_data=0x10.
- addi x4,x1,-1 (0xFFF08213) with x1=5 -> alu_b=0xFFFFFFFF, alu_ctrl=000, wb_data=4.
- addi x0,x1,1 (0x00108013) -> no wb_valid; next instruction is accepted 4 cycles later. Then instr 0x0000007F -> illegal pulses 1 cycle after the handshake, no wb_valid, instr_ready returns 2 cycles after the handshake.
- Assert rst in EXEC of an add -> no wb_valid; instr_ready=1 the cycle after rst deasserts; all outputs are zero.
